// File: rtl/pulse_meas_sched_if.sv
// Result channel of the pulse measurement scheduler: one measured value per
// channel visit, held until the consumer accepts it with res_ready.
interface pulse_meas_sched_if #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
);
  logic [CNT_W-1:0] res_data;
  logic [CH_W-1:0]  res_ch;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data,
    output res_ch,
    output res_timeout,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_ch,
    input  res_timeout,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/pulse_meas_sched.sv
// Round-robin pulse period meter. Visits each enabled channel in turn, waits
// for a rising edge, then counts clock cycles until one or two further rising
// edges have been seen, and presents the count on the result channel.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not scanning; busy low
// SELECT   | pick next enabled channel, latch mode, clear counters
// ARM      | wait for the first rising edge on the selected channel
// MEASURE  | count cycles until the final rising edge (1 or 2 periods)
// DONE     | result held on res_* until accepted
module pulse_meas_sched #(
  parameter int               NCH     = 4,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [1:0]     mode,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] pulse_in,
  output logic           busy,
  pulse_meas_sched_if.master res
);

  localparam int              CH_W   = 2;
  // One bit wider than the counter so cnt+1 can be compared against TIMEOUT
  // even when TIMEOUT is the all-ones value.
  localparam logic [CNT_W:0]  TO_EXT = {1'b0, TIMEOUT};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARM,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CH_W-1:0]  cur_ch, cur_ch_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       ecnt, ecnt_n;
  logic [1:0]       mode_lat, mode_lat_n;
  logic [CNT_W-1:0] res_data_n;
  logic [CH_W-1:0]  res_ch_n;
  logic             res_timeout_n;

  logic [NCH-1:0]   sync1, sync2, hist;
  logic [NCH-1:0]   rise_all;
  logic             rise;
  logic [CH_W-1:0]  nxt_ch;
  logic             nxt_found;
  logic [CNT_W:0]   cnt_inc;
  logic             at_limit;
  logic             start_ok;
  logic             abort;
  logic             last_edge;

  // Bring the asynchronous pulse inputs into clk and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise_all = sync2 & ~hist;
  assign rise     = rise_all[cur_ch];

  // Next enabled channel strictly after cur_ch, wrapping so cur_ch comes last.
  always_comb begin
    nxt_ch    = cur_ch;
    nxt_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!nxt_found && ch_en[(int'(cur_ch) + i) % NCH]) begin
        nxt_ch    = CH_W'((int'(cur_ch) + i) % NCH);
        nxt_found = 1'b1;
      end
    end
  end

  assign cnt_inc   = {1'b0, cnt} + 1'b1;
  assign at_limit  = (cnt_inc == TO_EXT);
  assign start_ok  = run && (mode != 2'd0) && (ch_en != '0);
  assign abort     = !run || (mode == 2'd0);
  assign last_edge = ((ecnt + 2'd1) == mode_lat);

  // Next-state and datapath updates; everything holds unless a branch says otherwise.
  always_comb begin
    state_n       = state;
    cur_ch_n      = cur_ch;
    cnt_n         = cnt;
    ecnt_n        = ecnt;
    mode_lat_n    = mode_lat;
    res_data_n    = res.res_data;
    res_ch_n      = res.res_ch;
    res_timeout_n = res.res_timeout;

    case (state)
      S_IDLE: begin
        if (start_ok) state_n = S_SELECT;
      end

      S_SELECT: begin
        if (nxt_found) begin
          cur_ch_n   = nxt_ch;
          mode_lat_n = (mode == 2'd2) ? 2'd2 : 2'd1;
          cnt_n      = '0;
          ecnt_n     = '0;
          state_n    = S_ARM;
        end else begin
          state_n    = S_IDLE;
        end
      end

      S_ARM: begin
        if (abort) begin
          cnt_n         = '0;
          res_data_n    = '0;
          res_ch_n      = '0;
          res_timeout_n = 1'b0;
          state_n       = S_IDLE;
        end else if (rise) begin
          cnt_n   = '0;
          state_n = S_MEASURE;
        end else if (at_limit) begin
          res_data_n    = TIMEOUT;
          res_ch_n      = cur_ch;
          res_timeout_n = 1'b1;
          state_n       = S_DONE;
        end else begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end
      end

      S_MEASURE: begin
        if (abort) begin
          cnt_n         = '0;
          res_data_n    = '0;
          res_ch_n      = '0;
          res_timeout_n = 1'b0;
          state_n       = S_IDLE;
        end else if (rise && last_edge) begin
          // A completing edge on the limit cycle still yields a real result.
          res_data_n    = cnt_inc[CNT_W-1:0];
          res_ch_n      = cur_ch;
          res_timeout_n = 1'b0;
          state_n       = S_DONE;
        end else if (at_limit) begin
          res_data_n    = TIMEOUT;
          res_ch_n      = cur_ch;
          res_timeout_n = 1'b1;
          state_n       = S_DONE;
        end else begin
          cnt_n = cnt_inc[CNT_W-1:0];
          if (rise) ecnt_n = ecnt + 2'd1;
        end
      end

      S_DONE: begin
        if (res.res_ready) state_n = start_ok ? S_SELECT : S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cur_ch          <= CH_W'(NCH - 1);
      cnt             <= '0;
      ecnt            <= '0;
      mode_lat        <= 2'd1;
      res.res_data    <= '0;
      res.res_ch      <= '0;
      res.res_timeout <= 1'b0;
    end else begin
      state           <= state_n;
      cur_ch          <= cur_ch_n;
      cnt             <= cnt_n;
      ecnt            <= ecnt_n;
      mode_lat        <= mode_lat_n;
      res.res_data    <= res_data_n;
      res.res_ch      <= res_ch_n;
      res.res_timeout <= res_timeout_n;
    end
  end

  assign res.res_valid = (state == S_DONE);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_pulse_meas_sched.sv
// Bench for pulse_meas_sched: periodic pulse sources per channel, a
// round-robin / period model of the expected results, and scenario tasks.
module tb_pulse_meas_sched;

  localparam int          NCH   = 4;
  localparam int          CNT_W = 16;
  localparam logic [15:0] TO    = 16'd1000;

  logic           clk = 1'b0;
  logic           rst;
  logic           run;
  logic [1:0]     mode;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] pulse_in;
  logic           busy;

  pulse_meas_sched_if #(.CNT_W(CNT_W), .CH_W(2)) res_if ();

  pulse_meas_sched #(.NCH(NCH), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mode     (mode),
    .ch_en    (ch_en),
    .pulse_in (pulse_in),
    .busy     (busy),
    .res      (res_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int per[NCH] = '{default: 0};
  int ph[NCH]  = '{default: 0};
  int model_last = NCH - 1;

  // Pulse sources: channel c goes high for 3 cycles every per[c] cycles; 0 = held low.
  initial begin
    pulse_in = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < NCH; c++) begin
        if (per[c] == 0) begin
          pulse_in[c] = 1'b0;
        end else begin
          pulse_in[c] = (ph[c] < 3);
          ph[c] = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
        end
      end
    end
  end

  task automatic set_per(input int c, input int p);
    per[c] = p;
    ph[c]  = 0;
  endtask

  // Round-robin model: first enabled channel after 'last', 'last' itself last.
  function automatic int next_ch(input int last, input logic [3:0] mask);
    for (int i = 1; i <= NCH; i++)
      if (mask[(last + i) % NCH]) return (last + i) % NCH;
    return last;
  endfunction

  // Expected result from the pulse period and measurement mode.
  function automatic void expect_result(input int p, input logic [1:0] m,
                                        output int d, output bit t);
    int span;
    span = (m == 2'd2) ? 2 * p : p;
    if (p == 0 || span > int'(TO)) begin
      d = int'(TO);
      t = 1'b1;
    end else begin
      d = span;
      t = 1'b0;
    end
  endfunction

  task automatic wait_result(input int budget, output logic ok, output logic [15:0] d,
                             output logic [1:0] c, output logic t);
    ok = 1'b0; d = '0; c = '0; t = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (res_if.res_valid === 1'b1) begin
        ok = 1'b1;
        d  = res_if.res_data;
        c  = res_if.res_ch;
        t  = res_if.res_timeout;
      end
    end
  endtask

  task automatic stop_dut(input string name);
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s stop: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic run_scan(input string name, input logic [3:0] mask,
                          input logic [1:0] m, input int nres);
    logic ok;
    logic [15:0] d;
    logic [1:0] c;
    logic t;
    int ec, ed;
    bit et;
    ch_en = mask;
    mode  = m;
    run   = 1'b1;
    for (int k = 0; k < nres; k++) begin
      ec = next_ch(model_last, mask);
      expect_result(per[ec], m, ed, et);
      wait_result(4000, ok, d, c, t);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s[%0d] result: res_valid never seen in 4000 cycles, required 1", name, k);
      end else begin
        total++;
        if (int'(c) !== ec) begin
          bad++;
          $display("FAIL %s[%0d] res_ch: got %0d, required %0d", name, k, c, ec);
        end
        total++;
        if (int'(d) !== ed) begin
          bad++;
          $display("FAIL %s[%0d] res_data: got %0d, required %0d", name, k, d, ed);
        end
        total++;
        if (t !== et) begin
          bad++;
          $display("FAIL %s[%0d] res_timeout: got %b, required %b", name, k, t, et);
        end
      end
      model_last = ec;
    end
    stop_dut(name);
    // The last handshake happened with run high, so one more channel was selected.
    model_last = next_ch(model_last, mask);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b, required 0", busy); end
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL reset res_valid: got %b, required 0", res_if.res_valid); end
    total++; if (res_if.res_data !== 16'd0) begin bad++; $display("FAIL reset res_data: got %0d, required 0", res_if.res_data); end
    total++; if (res_if.res_ch !== 2'd0) begin bad++; $display("FAIL reset res_ch: got %0d, required 0", res_if.res_ch); end
    total++; if (res_if.res_timeout !== 1'b0) begin bad++; $display("FAIL reset res_timeout: got %b, required 0", res_if.res_timeout); end
    rst = 1'b0;
    model_last = NCH - 1;
    @(negedge clk);
  endtask

  task automatic test_one_period;
    set_per(0, 100);
    run_scan("one_period", 4'b0001, 2'd1, 3);
    set_per(0, $urandom_range(20, 300));
    run_scan("one_period_m3", 4'b0001, 2'd3, 2);
  endtask

  task automatic test_two_period;
    set_per(0, 100);
    run_scan("two_period", 4'b0001, 2'd2, 2);
    set_per(0, $urandom_range(20, 400));
    run_scan("two_period_rnd", 4'b0001, 2'd2, 2);
  endtask

  task automatic test_alternate;
    set_per(1, 50);
    set_per(3, 70);
    run_scan("alternate", 4'b1010, 2'd1, 4);
  endtask

  task automatic test_random_scan;
    logic [3:0] mask;
    logic [1:0] m;
    for (int r = 0; r < 3; r++) begin
      mask = 4'($urandom_range(1, 15));
      m    = 2'($urandom_range(1, 3));
      for (int c = 0; c < NCH; c++) set_per(c, $urandom_range(20, 200));
      run_scan("random_scan", mask, m, 6);
    end
  endtask

  task automatic test_timeout_arm;
    set_per(2, 0);
    run_scan("arm_timeout", 4'b0100, 2'd1, 2);
  endtask

  task automatic test_boundary;
    set_per(0, 1000);
    run_scan("edge_on_limit", 4'b0001, 2'd1, 1);
    set_per(0, 600);
    run_scan("measure_timeout", 4'b0001, 2'd2, 1);
  endtask

  task automatic test_backpressure;
    logic ok;
    logic [15:0] d;
    logic [1:0] c;
    logic t;
    set_per(0, 80);
    ch_en = 4'b0001;
    mode  = 2'd1;
    res_if.res_ready = 1'b0;
    run = 1'b1;
    wait_result(4000, ok, d, c, t);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL backpressure result: res_valid never seen in 4000 cycles, required 1");
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++; if (res_if.res_valid !== 1'b1) begin bad++; $display("FAIL backpressure hold res_valid[%0d]: got %b, required 1", i, res_if.res_valid); end
      total++; if (res_if.res_data !== 16'd80) begin bad++; $display("FAIL backpressure hold res_data[%0d]: got %0d, required 80", i, res_if.res_data); end
      total++; if (res_if.res_ch !== 2'd0) begin bad++; $display("FAIL backpressure hold res_ch[%0d]: got %0d, required 0", i, res_if.res_ch); end
    end
    res_if.res_ready = 1'b1;
    @(negedge clk);
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL backpressure release res_valid: got %b, required 0", res_if.res_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL backpressure rearm busy: got %b, required 1", busy); end
    stop_dut("backpressure");
    model_last = 0;
  endtask

  task automatic test_abort_arm;
    int seen;
    set_per(0, 0);
    ch_en = 4'b0001;
    mode  = 2'd1;
    run   = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_arm pre busy: got %b, required 1", busy); end
    run = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_arm busy: got %b, required 0", busy); end
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL abort_arm res_valid: got %b, required 0", res_if.res_valid); end
    total++; if (res_if.res_data !== 16'd0) begin bad++; $display("FAIL abort_arm res_data: got %0d, required 0", res_if.res_data); end
    total++; if (res_if.res_ch !== 2'd0) begin bad++; $display("FAIL abort_arm res_ch: got %0d, required 0", res_if.res_ch); end
    total++; if (res_if.res_timeout !== 1'b0) begin bad++; $display("FAIL abort_arm res_timeout: got %b, required 0", res_if.res_timeout); end
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (res_if.res_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_arm no_result: res_valid seen %0d cycles, required 0", seen); end
    model_last = 0;
  endtask

  task automatic test_reset_measure;
    int seen;
    set_per(0, 300);
    ch_en = 4'b0001;
    mode  = 2'd1;
    run   = 1'b1;
    repeat (150) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_measure pre busy: got %b, required 1", busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_measure busy: got %b, required 0", busy); end
    total++; if (res_if.res_valid !== 1'b0) begin bad++; $display("FAIL reset_measure res_valid: got %b, required 0", res_if.res_valid); end
    total++; if (res_if.res_data !== 16'd0) begin bad++; $display("FAIL reset_measure res_data: got %0d, required 0", res_if.res_data); end
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (res_if.res_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_measure no_result: res_valid seen %0d cycles, required 0", seen); end
    model_last = NCH - 1;
  endtask

  initial begin
    rst   = 1'b1;
    run   = 1'b0;
    mode  = 2'd0;
    ch_en = '0;
    res_if.res_ready = 1'b1;
    test_reset;
    test_one_period;
    test_two_period;
    test_alternate;
    test_random_scan;
    test_timeout_arm;
    test_boundary;
    test_backpressure;
    test_abort_arm;
    test_reset_measure;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
